// File: rtl/nnrv_wb_arb_pkg.sv
// Shared constants and types for the writeback arbiter: register-file
// geometry, the default data width, and the starvation FSM state encoding.
package nnrv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_IDX_W    = 5;
    localparam int NUM_REGS     = 32;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_PEND  = 2'd1,
        WB_STALL = 2'd2
    } wb_arb_state_e;

    // One-hot mask with the bit for register idx set.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/nnrv_wb_arb_if.sv
// Bundle of pipeline writeback, long-latency result and regfile write
// signals around the arbiter. The arbiter uses the slave modport; whoever
// feeds it uses master. With NNRV_WB_ARB_STATS_EN defined the bundle also
// carries the forced-stall cycle counter.
interface nnrv_wb_arb_if
    import nnrv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic                 i_pipe_w_en;
    logic [REG_IDX_W-1:0] i_pipe_w;
    logic [XLEN-1:0]      i_pipe_w_reg;
    logic                 o_pipe_stall;
    logic                 i_ll_valid;
    logic                 o_ll_ready;
    logic [REG_IDX_W-1:0] i_ll_rd;
    logic [XLEN-1:0]      i_ll_data;
    logic                 o_reg_w_en;
    logic [REG_IDX_W-1:0] o_reg_w;
    logic [XLEN-1:0]      o_reg_w_reg;
    logic [NUM_REGS-1:0]  o_ll_pend;
`ifdef NNRV_WB_ARB_STATS_EN
    logic [15:0]          o_stall_cnt;

    modport master (
        output i_pipe_w_en, i_pipe_w, i_pipe_w_reg, i_ll_valid, i_ll_rd, i_ll_data,
        input  o_pipe_stall, o_ll_ready, o_reg_w_en, o_reg_w, o_reg_w_reg, o_ll_pend, o_stall_cnt
    );
    modport slave (
        input  i_pipe_w_en, i_pipe_w, i_pipe_w_reg, i_ll_valid, i_ll_rd, i_ll_data,
        output o_pipe_stall, o_ll_ready, o_reg_w_en, o_reg_w, o_reg_w_reg, o_ll_pend, o_stall_cnt
    );
`else
    modport master (
        output i_pipe_w_en, i_pipe_w, i_pipe_w_reg, i_ll_valid, i_ll_rd, i_ll_data,
        input  o_pipe_stall, o_ll_ready, o_reg_w_en, o_reg_w, o_reg_w_reg, o_ll_pend
    );
    modport slave (
        input  i_pipe_w_en, i_pipe_w, i_pipe_w_reg, i_ll_valid, i_ll_rd, i_ll_data,
        output o_pipe_stall, o_ll_ready, o_reg_w_en, o_reg_w, o_reg_w_reg, o_ll_pend
    );
`endif

endinterface

// File: rtl/nnrv_wb_arb_fifo.sv
// Small synchronous FIFO of {rd, data} long-latency results. Exposes the
// head entry combinationally, occupancy, and per-entry valid/rd so the
// parent can build the pending-register scoreboard. DEPTH must be a power
// of two so the pointers wrap naturally.
module nnrv_wb_fifo
    import nnrv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [REG_IDX_W-1:0]            push_rd,
    input  logic [XLEN-1:0]                 push_data,
    input  logic                            pop,
    output logic [REG_IDX_W-1:0]            head_rd,
    output logic [XLEN-1:0]                 head_data,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH-1:0]                entry_valid,
    output logic [DEPTH-1:0][REG_IDX_W-1:0] entry_rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [REG_IDX_W-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]      data_mem [DEPTH];

    // Pointer and occupancy tracking; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload storage; contents are meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= push_rd;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic valid_reg;

            // Per-entry valid: set when written, cleared when drained. The parent never
            // pushes into a full FIFO, so push and pop never target the same slot.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    valid_reg <= 1'b1;
                end else if (pop && (rd_ptr_reg == PTR_W'(gi))) begin
                    valid_reg <= 1'b0;
                end
            end

            assign entry_valid[gi] = valid_reg;
            assign entry_rd[gi]    = rd_mem[gi];
        end
    endgenerate

    assign head_rd   = rd_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];
    assign count     = count_reg;
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/nnrv_wb_arb.sv
// Register-file write-port arbiter between in-order pipeline writeback and
// an out-of-band long-latency unit. Pipeline writes win; buffered LL results
// drain in free slots, and a starvation counter forces a one-cycle pipeline
// stall so a waiting result is never blocked forever.
// Optional feature macro: NNRV_WB_ARB_STATS_EN adds a saturating count of
// forced-stall cycles on the interface (o_stall_cnt).
module nnrv_wb_arb
    import nnrv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    nnrv_wb_arb_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    wb_arb_state_e state_reg, state_next;
    logic [STV_W-1:0] starve_reg, starve_next;

    logic                                 fifo_push;
    logic                                 head_pop;
    logic [REG_IDX_W-1:0]                 fifo_head_rd;
    logic [XLEN-1:0]                      fifo_head_data;
    logic [CNT_W-1:0]                     fifo_count;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic [FIFO_DEPTH-1:0]                entry_valid;
    logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] entry_rd;
    logic [NUM_REGS-1:0]                  entry_mask [FIFO_DEPTH];
    logic [NUM_REGS-1:0]                  pend_vec;

    logic pipe_stall;
    logic pipe_grant;
    logic last_drain;

    logic                 reg_w_en_reg;
    logic [REG_IDX_W-1:0] reg_w_reg;
    logic [XLEN-1:0]      reg_w_data_reg;

    // Readiness looks at occupancy only, so a full FIFO refuses even while draining.
    // Results for x0 are acknowledged but never stored.
    assign fifo_push  = bus.i_ll_valid && !fifo_full && (bus.i_ll_rd != '0);
    assign pipe_stall = (state_reg == WB_STALL);
    // A pipeline write to x0 does not occupy the port.
    assign pipe_grant = bus.i_pipe_w_en && !pipe_stall && (bus.i_pipe_w != '0);
    assign head_pop   = !fifo_empty && !pipe_grant;
    assign last_drain = head_pop && !fifo_push && (fifo_count == CNT_W'(1));

    nnrv_wb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (i_clk),
        .rst         (i_rst),
        .push        (fifo_push),
        .push_rd     (bus.i_ll_rd),
        .push_data   (bus.i_ll_data),
        .pop         (head_pop),
        .head_rd     (fifo_head_rd),
        .head_data   (fifo_head_data),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // Starvation FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= WB_IDLE;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

    // Next state: count cycles the head is denied; on the STARVE_MAX-th denial
    // the following cycle is a forced stall in which the head is guaranteed to drain.
    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        case (state_reg)
            WB_IDLE: begin
                starve_next = '0;
                if (fifo_push) state_next = WB_PEND;
            end
            WB_PEND: begin
                if (head_pop) begin
                    starve_next = '0;
                    state_next  = last_drain ? WB_IDLE : WB_PEND;
                end else begin
                    starve_next = starve_reg + 1'b1;
                    if (starve_next == STV_W'(STARVE_MAX)) state_next = WB_STALL;
                end
            end
            WB_STALL: begin
                starve_next = '0;
                state_next  = last_drain ? WB_IDLE : WB_PEND;
            end
            default: begin
                state_next  = WB_IDLE;
                starve_next = '0;
            end
        endcase
    end

    // Register the granted write; idle cycles present an all-zero write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reg_w_en_reg   <= 1'b0;
            reg_w_reg      <= '0;
            reg_w_data_reg <= '0;
        end else if (pipe_grant) begin
            reg_w_en_reg   <= 1'b1;
            reg_w_reg      <= bus.i_pipe_w;
            reg_w_data_reg <= bus.i_pipe_w_reg;
        end else if (head_pop) begin
            reg_w_en_reg   <= 1'b1;
            reg_w_reg      <= fifo_head_rd;
            reg_w_data_reg <= fifo_head_data;
        end else begin
            reg_w_en_reg   <= 1'b0;
            reg_w_reg      <= '0;
            reg_w_data_reg <= '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_pend
            assign entry_mask[gi] = entry_valid[gi] ? reg_onehot(entry_rd[gi]) : '0;
        end
    endgenerate

    // Pending scoreboard: a bit stays set while any buffered entry still targets it.
    always_comb begin
        pend_vec = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            pend_vec = pend_vec | entry_mask[i];
        end
    end

`ifdef NNRV_WB_ARB_STATS_EN
    logic [15:0] stall_cnt_reg;

    // Saturating count of forced-stall cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_reg <= '0;
        end else if (pipe_stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.o_stall_cnt = stall_cnt_reg;
`endif

    assign bus.o_pipe_stall = pipe_stall;
    assign bus.o_ll_ready   = !fifo_full;
    assign bus.o_reg_w_en   = reg_w_en_reg;
    assign bus.o_reg_w      = reg_w_reg;
    assign bus.o_reg_w_reg  = reg_w_data_reg;
    assign bus.o_ll_pend    = pend_vec;

endmodule
